// File: rtl/hyperbus_ck_seq.sv
// HyperBus CK/CS frame sequencer: CS setup, N gated CK beats with stall/abort, CS hold, CS-high recovery.
// Optional tCSM truncation guarded by `HYPERBUS_CK_SEQ_TCSM_EN.
module hyperbus_ck_seq #(
  parameter int unsigned CntWidth    = 16,
  parameter int unsigned TCssCycles  = 2,
  parameter int unsigned TCshCycles  = 1,
  parameter int unsigned TCshiCycles = 2,
  parameter int unsigned TCsmCycles  = 400
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [CntWidth-1:0] req_cycles_i,
  input  logic                stall_i,
  input  logic                abort_i,
  output logic                ck_en_o,
  output logic                cs_no,
  output logic                beat_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                tcsm_err_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSetup = 3'd1;
  localparam logic [2:0] StClk   = 3'd2;
  localparam logic [2:0] StHold  = 3'd3;
  localparam logic [2:0] StHigh  = 3'd4;

  localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);
  localparam logic [CntWidth-1:0] CssLast  = CntWidth'(TCssCycles - 1);
  localparam logic [CntWidth-1:0] CshLast  = CntWidth'(TCshCycles - 1);
  localparam logic [CntWidth-1:0] CshiLast = CntWidth'(TCshiCycles - 1);

  // Elaboration-time range checks on the timing parameters
  if (TCssCycles == 0 || (64'(TCssCycles) >> CntWidth) != 64'd0) begin : g_bad_tcss
    $error("TCssCycles must be >= 1 and fit in CntWidth bits");
  end
  if (TCshCycles == 0 || (64'(TCshCycles) >> CntWidth) != 64'd0) begin : g_bad_tcsh
    $error("TCshCycles must be >= 1 and fit in CntWidth bits");
  end
  if (TCshiCycles == 0 || (64'(TCshiCycles) >> CntWidth) != 64'd0) begin : g_bad_tcshi
    $error("TCshiCycles must be >= 1 and fit in CntWidth bits");
  end

  logic [2:0]          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [CntWidth-1:0] tmr_q, tmr_d;
  logic                ck_en_q, ck_en_d;
  logic                cs_n_q, cs_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic                tcsm_hit_c;
  logic                stop_c;

`ifdef HYPERBUS_CK_SEQ_TCSM_EN
  if (TCsmCycles <= TCshCycles) begin : g_bad_tcsm
    $error("TCsmCycles must exceed TCshCycles");
  end

  // Counts cs_no-low cycles; trips one cycle before the hold phase must start
  localparam logic [CntWidth-1:0] CsmTrip = CntWidth'(TCsmCycles - TCshCycles - 1);
  logic [CntWidth-1:0] csm_q, csm_d;

  always_comb begin
    csm_d = cs_n_q ? '0 : csm_q + CntOne;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) csm_q <= '0;
    else       csm_q <= csm_d;
  end

  assign tcsm_hit_c = ((state_q == StSetup) || (state_q == StClk)) && (csm_q == CsmTrip);
`else
  assign tcsm_hit_c = 1'b0;
`endif

  assign stop_c = abort_i || tcsm_hit_c;

  // Next-state, counters and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    case (state_q)
      StIdle: begin
        if (req_valid_i && ready_q) begin
          state_d = StSetup;
          cnt_d   = req_cycles_i;
          tmr_d   = CssLast;
        end
      end
      StSetup: begin
        if (stop_c || (tmr_q == '0 && cnt_q == '0)) begin
          state_d = StHold;
          cnt_d   = '0;
          tmr_d   = CshLast;
        end else if (tmr_q == '0) begin
          state_d = StClk;
        end else begin
          tmr_d = tmr_q - CntOne;
        end
      end
      StClk: begin
        if (ck_en_q) cnt_d = cnt_q - CntOne;
        // A beat in flight this cycle still counts when it is the last one
        if (stop_c || (ck_en_q && cnt_q == CntOne)) begin
          state_d = StHold;
          cnt_d   = '0;
          tmr_d   = CshLast;
        end
      end
      StHold: begin
        if (tmr_q == '0) begin
          state_d = StHigh;
          tmr_d   = CshiLast;
        end else begin
          tmr_d = tmr_q - CntOne;
        end
      end
      StHigh: begin
        if (tmr_q == '0) state_d = StIdle;
        else             tmr_d   = tmr_q - CntOne;
      end
      default: state_d = StIdle;
    endcase

    ck_en_d = (state_d == StClk) && !stall_i;
    cs_n_d  = !((state_d == StSetup) || (state_d == StClk) || (state_d == StHold));
    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StIdle);
    done_d  = (state_d == StHigh) && (state_q == StHold);
    err_d   = tcsm_hit_c;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tmr_q   <= '0;
      ck_en_q <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      ck_en_q <= ck_en_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = ready_q;
  assign ck_en_o     = ck_en_q;
  assign beat_o      = ck_en_q;
  assign cs_no       = cs_n_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign tcsm_err_o  = err_q;

endmodule

// File: tb/tb_hyperbus_ck_seq.sv
// Bench for hyperbus_ck_seq: per-frame timeline model built from frame rules, checked cycle by cycle.
module tb_hyperbus_ck_seq;
  localparam int CW    = 16;
  localparam int TCSS  = 2;
  localparam int TCSH  = 1;
  localparam int TCSHI = 2;
  localparam int TCSM  = 20;
  localparam int MAXR  = 512;
`ifdef HYPERBUS_CK_SEQ_TCSM_EN
  localparam bit TCSM_ON = 1'b1;
`else
  localparam bit TCSM_ON = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [CW-1:0] req_cycles_i;
  logic          stall_i;
  logic          abort_i;
  logic          ck_en_o;
  logic          cs_no;
  logic          beat_o;
  logic          busy_o;
  logic          done_o;
  logic          tcsm_err_o;

  always #5 clk_i = ~clk_i;

  hyperbus_ck_seq #(
    .CntWidth(CW), .TCssCycles(TCSS), .TCshCycles(TCSH),
    .TCshiCycles(TCSHI), .TCsmCycles(TCSM)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_cycles_i(req_cycles_i), .stall_i(stall_i), .abort_i(abort_i), .ck_en_o(ck_en_o),
    .cs_no(cs_no), .beat_o(beat_o), .busy_o(busy_o), .done_o(done_o), .tcsm_err_o(tcsm_err_o)
  );

  int vectors = 0;
  int fails   = 0;

  bit stall_a[MAXR];
  bit abort_a[MAXR];
  bit e_cs[MAXR], e_ck[MAXR], e_done[MAXR], e_err[MAXR], e_busy[MAXR], e_rdy[MAXR];
  int last_r;

  task automatic chk(input string tag, input int r, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s r=%0d observed=%b expected=%b", tag, r, obs, exp);
    end
  endtask

  task automatic check_cycle(input int r);
    chk("cs_no", r, cs_no, e_cs[r]);
    chk("ck_en", r, ck_en_o, e_ck[r]);
    chk("beat", r, beat_o, e_ck[r]);
    chk("busy", r, busy_o, e_busy[r]);
    chk("done", r, done_o, e_done[r]);
    chk("ready", r, req_ready_o, e_rdy[r]);
    chk("tcsm_err", r, tcsm_err_o, e_err[r]);
  endtask

  // Frame timeline: r=0 is the handshake cycle, CS low from r=1
  task automatic build_model(input int n);
    int hs, beats, r;
    bit in_clk, tc;
    for (int i = 0; i < MAXR; i++) begin
      e_cs[i] = 1'b1; e_ck[i] = 1'b0; e_done[i] = 1'b0;
      e_err[i] = 1'b0; e_busy[i] = 1'b0; e_rdy[i] = 1'b0;
    end
    e_rdy[0] = 1'b1;
    hs = -1;
    beats = 0;
    r = 1;
    while (hs < 0 && r < MAXR - TCSH - TCSHI - 2) begin
      in_clk = (r > TCSS) && (n > 0);
      e_cs[r] = 1'b0;
      e_busy[r] = 1'b1;
      if (in_clk && !stall_a[r-1]) begin
        e_ck[r] = 1'b1;
        beats++;
      end
      tc = TCSM_ON && (r == TCSM - TCSH);
      if ((in_clk && beats == n) || (n == 0 && r == TCSS) || abort_a[r] || tc) begin
        hs = r + 1;
        e_err[hs] = tc;
      end
      r++;
    end
    if (hs < 0) begin
      vectors++;
      fails++;
      $error("FAIL model_bound n=%0d observed=unbounded expected=frame<%0d", n, MAXR);
      hs = r;
    end
    for (int k = 0; k < TCSH; k++) begin
      e_cs[hs+k] = 1'b0;
      e_busy[hs+k] = 1'b1;
    end
    for (int k = 0; k < TCSHI; k++) e_busy[hs+TCSH+k] = 1'b1;
    e_done[hs+TCSH] = 1'b1;
    last_r = hs + TCSH + TCSHI - 1;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXR; i++) begin
      stall_a[i] = 1'b0;
      abort_a[i] = 1'b0;
    end
  endtask

  task automatic run_frame(input int n, input int idle);
    build_model(n);
    for (int i = 0; i < idle; i++) begin
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      stall_i = 1'($urandom_range(0, 1));
      abort_i = 1'($urandom_range(0, 1));
      check_cycle(0);
    end
    @(posedge clk_i); #1;
    req_valid_i = 1'b1;
    req_cycles_i = CW'(n);
    stall_i = stall_a[0];
    abort_i = abort_a[0];
    check_cycle(0);
    for (int r = 1; r <= last_r; r++) begin
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      stall_i = stall_a[r];
      abort_i = abort_a[r];
      check_cycle(r);
    end
    stall_i = 1'b0;
    abort_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0;
    req_valid_i = 1'b0;
    req_cycles_i = '0;
    stall_i = 1'b0;
    abort_i = 1'b0;
    #1 rst_i = 1'b1;
    #2;
    chk("rst_cs_no", 0, cs_no, 1'b1);
    chk("rst_ck_en", 0, ck_en_o, 1'b0);
    chk("rst_ready", 0, req_ready_o, 1'b1);
    chk("rst_busy", 0, busy_o, 1'b0);
    chk("rst_done", 0, done_o, 1'b0);
    chk("rst_err", 0, tcsm_err_o, 1'b0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b0;

    clear_stim(); run_frame(4, 0);
    clear_stim(); run_frame(0, 1);
    clear_stim(); stall_a[4] = 1'b1; stall_a[5] = 1'b1; stall_a[6] = 1'b1; run_frame(6, 0);
    clear_stim(); abort_a[13] = 1'b1; run_frame(100, 0);
    clear_stim(); run_frame(2, 0);
    clear_stim(); run_frame(50, 1);
    clear_stim(); abort_a[10] = 1'b1; run_frame(65535, 0);
    clear_stim(); abort_a[1] = 1'b1; run_frame(5, 0);
    clear_stim(); abort_a[5] = 1'b1; run_frame(3, 0);
    clear_stim(); stall_a[6] = 1'b1; abort_a[6] = 1'b1; run_frame(8, 0);

    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < MAXR; i++) begin
        stall_a[i] = ($urandom_range(0, 3) == 0);
        abort_a[i] = ($urandom_range(0, 29) == 0);
      end
      run_frame(int'($urandom_range(0, 12)), int'($urandom_range(0, 2)));
    end

    // Reset asserted while clocking
    clear_stim();
    @(posedge clk_i); #1;
    req_valid_i = 1'b1;
    req_cycles_i = CW'(20);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    chk("pre_rst_ck_en", 5, ck_en_o, 1'b1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_ck_en", 5, ck_en_o, 1'b0);
    chk("mid_rst_cs_no", 5, cs_no, 1'b1);
    chk("mid_rst_ready", 5, req_ready_o, 1'b1);
    chk("mid_rst_busy", 5, busy_o, 1'b0);
    @(negedge clk_i) rst_i = 1'b0;
    run_frame(2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
